mpi_eth_top_sim: RTL and testbench



---
 rtl/mpi_eth_top_sim.sv | 125 ++++++++++++
 tb/tb_mpi_eth_top_sim.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpi_eth_top_sim.sv
// Ethernet loopback stand-in for the debug shell: swaps destination/source MAC
// in each frame and returns it through a store-and-forward FIFO.
module mpi_eth_top_sim #(
    parameter int DEPTH = 512
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [63:0] data,
    input  logic [7:0]  keep,
    input  logic        last,
    input  logic        valid,
    output logic        ready,
    output logic [63:0] data_out,
    output logic [7:0]  keep_out,
    output logic        last_out,
    output logic        valid_out,
    input  logic        ready_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   hold_data;
    logic [7:0]    hold_keep;
    logic          hold_last;
    logic          hold_valid;
    logic [1:0]    beat_idx;

    logic [72:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] level;

    logic          accept;
    logic          swap;
    logic          wr_en;
    logic          rd_en;
    logic          pkt_inc;
    logic          pkt_dec;
    logic [63:0]   wr_beat;
    logic [63:0]   load_beat;
    logic [72:0]   wr_word;
    logic [72:0]   head;

    // The hold register counts against capacity so a held last beat can always be flushed.
    assign level  = fifo_count + CW'(hold_valid);
    assign ready  = !resetn && (level < CW'(DEPTH));
    assign accept = valid && ready;

    // Beat 0 sits in hold when beat 1 arrives, so both halves of the MAC swap are available.
    assign swap      = accept && hold_valid && (beat_idx == 2'd1);
    assign wr_beat   = swap ? {hold_data[15:0], data[31:0], hold_data[63:48]} : hold_data;
    assign load_beat = swap ? {data[63:32], hold_data[47:16]} : data;
    assign wr_en     = hold_valid && (accept || hold_last);
    assign wr_word   = {hold_last, hold_keep, wr_beat};

    assign head      = mem[rd_ptr];
    assign valid_out = (fifo_count != '0) && ((pkt_count != '0) || (level == CW'(DEPTH)));
    assign rd_en     = valid_out && ready_out;
    assign data_out  = valid_out ? head[63:0]  : '0;
    assign keep_out  = valid_out ? head[71:64] : '0;
    assign last_out  = valid_out ? head[72]    : 1'b0;

    assign pkt_inc = wr_en && hold_last;
    assign pkt_dec = rd_en && head[72];

    always_ff @(posedge clk) begin
        if (resetn) begin
            hold_data  <= '0;
            hold_keep  <= '0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
            beat_idx   <= 2'd0;
        end else if (accept) begin
            hold_data  <= load_beat;
            hold_keep  <= keep;
            hold_last  <= last;
            hold_valid <= 1'b1;
            if (last) begin
                beat_idx <= 2'd0;
            end else if (beat_idx == 2'd0) begin
                beat_idx <= 2'd1;
            end else begin
                beat_idx <= 2'd2;
            end
        end else if (wr_en) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            pkt_count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + CW'(1);
                2'b01:   pkt_count <= pkt_count - CW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mpi_eth_top_sim.sv
// Scoreboard bench for mpi_eth_top_sim: expected beats are queued as frames are
// driven and compared as they leave the output port.
module tb_mpi_eth_top_sim;

    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        valid;
    logic        ready;
    logic [63:0] data_out;
    logic [7:0]  keep_out;
    logic        last_out;
    logic        valid_out;
    logic        ready_out;

    int          assertCount = 0;
    int          failCount = 0;
    logic [72:0] expQ[$];
    logic [63:0] frameData[$];
    logic [7:0]  frameKeep[$];
    bit          monOn = 1'b0;
    bit          prevStall = 1'b0;
    bit          timedOut = 1'b0;
    logic [72:0] prevBeat = '0;
    logic [72:0] expBeat;

    always #5 clk = ~clk;

    mpi_eth_top_sim #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .data      (data),
        .keep      (keep),
        .last      (last),
        .valid     (valid),
        .ready     (ready),
        .data_out  (data_out),
        .keep_out  (keep_out),
        .last_out  (last_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    task automatic checkOutput(input string tag, input logic [72:0] observed, input logic [72:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Output monitor: scoreboard pops, idle-zero outputs and stall stability.
    always @(negedge clk) begin
        if (monOn) begin
            if (valid_out && ready_out) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_beat", 73'(valid_out), 73'd0);
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("beat", {last_out, keep_out, data_out}, expBeat);
                end
            end else if (!valid_out) begin
                checkOutput("idle_zero", {last_out, keep_out, data_out}, 73'd0);
            end
            if (valid_out && !ready_out && prevStall) begin
                checkOutput("stall_stable", {last_out, keep_out, data_out}, prevBeat);
            end
        end
        prevStall = monOn && valid_out && !ready_out;
        prevBeat  = {last_out, keep_out, data_out};
    end

    task automatic sendBeat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int waitCycles;
        waitCycles = 0;
        if (timedOut) return;
        data  = d;
        keep  = k;
        last  = l;
        valid = 1'b1;
        @(negedge clk);
        while (!ready && waitCycles < 600) begin
            waitCycles++;
            @(negedge clk);
        end
        if (!ready) begin
            checkOutput("accept_timeout", 73'(ready), 73'd1);
            timedOut = 1'b1;
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic buildFrame(input int n, input logic [31:0] seed);
        frameData.delete();
        frameKeep.delete();
        for (int i = 0; i < n; i++) begin
            frameData.push_back({seed + 32'(i), 32'hC0DE0000 | 32'(i * 7)});
            frameKeep.push_back((i == n - 1) ? (8'hFF >> seed[2:0]) : 8'hFF);
        end
    endtask

    // Reference model: MAC swap across beats 0 and 1 of multi-beat frames.
    task automatic pushFrame();
        int n;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [63:0] e;
        n = frameData.size();
        b0 = frameData[0];
        b1 = (n >= 2) ? frameData[1] : 64'd0;
        for (int i = 0; i < n; i++) begin
            if (n >= 2 && i == 0) begin
                e = {b0[15:0], b1[31:0], b0[63:48]};
            end else if (n >= 2 && i == 1) begin
                e = {b1[63:32], b0[47:16]};
            end else begin
                e = frameData[i];
            end
            expQ.push_back({(i == n - 1), frameKeep[i], e});
        end
    endtask

    task automatic applyStimulus(input int n, input logic [31:0] seed, input bit checkFill);
        buildFrame(n, seed);
        pushFrame();
        for (int i = 0; i < n; i++) begin
            sendBeat(frameData[i], frameKeep[i], (i == n - 1));
            if (checkFill) begin
                if (i + 1 < DEPTH) begin
                    checkOutput("ovs_wait", 73'(valid_out), 73'd0);
                end else if (i + 1 == DEPTH) begin
                    checkOutput("ovs_full", 73'(valid_out), 73'd1);
                end
            end
        end
    endtask

    task automatic waitDrain();
        int c;
        c = 0;
        while ((expQ.size() != 0 || valid_out) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        checkOutput("drain", 73'(expQ.size()), 73'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int c;
        resetn    = 1'b1;
        valid     = 1'b1;
        data      = 64'hFEEDFACECAFEBEEF;
        keep      = 8'hFF;
        last      = 1'b1;
        ready_out = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_ready", 73'(ready), 73'd0);
            checkOutput("rst_valid_out", 73'(valid_out), 73'd0);
            checkOutput("rst_data_out", 73'(data_out), 73'd0);
        end
        @(posedge clk);
        #1;
        resetn = 1'b0;
        valid  = 1'b0;
        monOn  = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 73'(ready), 73'd1);
        checkOutput("post_rst_valid_out", 73'(valid_out), 73'd0);
        @(posedge clk);
        #1;
        ready_out = 1'b1;

        // Single-beat frame passes unmodified, visible two edges after acceptance.
        expQ.push_back({1'b1, 8'hFF, 64'h0807060504030201});
        sendBeat(64'h0807060504030201, 8'hFF, 1'b1);
        @(negedge clk);
        checkOutput("lat_t1_valid", 73'(valid_out), 73'd0);
        @(negedge clk);
        checkOutput("lat_t2_valid", 73'(valid_out), 73'd1);
        checkOutput("lat_t2_data", 73'(data_out), 73'(64'h0807060504030201));
        checkOutput("lat_t2_keep", 73'(keep_out), 73'(8'hFF));
        checkOutput("lat_t2_last", 73'(last_out), 73'd1);
        @(posedge clk);
        #1;
        waitDrain();

        // Two-beat MAC swap with literal expectations.
        expQ.push_back({1'b0, 8'hFF, 64'h02010C0B0A090807});
        expQ.push_back({1'b1, 8'h0F, 64'h100F0E0D06050403});
        sendBeat(64'h0807060504030201, 8'hFF, 1'b0);
        sendBeat(64'h100F0E0D0C0B0A09, 8'h0F, 1'b1);
        waitDrain();

        // Back-to-back frames of mixed length; beat index must restart per frame.
        applyStimulus(3, 32'h11112222, 1'b0);
        applyStimulus(1, 32'h33334441, 1'b0);
        applyStimulus(2, 32'h55556663, 1'b0);
        applyStimulus(5, 32'h77778885, 1'b0);
        waitDrain();

        // Store-and-forward: nothing leaves until the last beat is in.
        buildFrame(4, 32'hABCD0006);
        pushFrame();
        for (int i = 0; i < 3; i++) begin
            sendBeat(frameData[i], frameKeep[i], 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("sf_hold", 73'(valid_out), 73'd0);
        end
        @(posedge clk);
        #1;
        sendBeat(frameData[3], frameKeep[3], 1'b1);
        c = 0;
        @(negedge clk);
        while (!valid_out && c < 10) begin
            @(negedge clk);
            c++;
        end
        for (int j = 0; j < 4; j++) begin
            checkOutput("sf_b2b", 73'(valid_out), 73'd1);
            if (j < 3) begin
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        waitDrain();

        // Backpressure: fill with single-beat frames until capacity is reached.
        ready_out = 1'b0;
        n = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            data  = {32'hB0B00000 | 32'(i), 32'(i) ^ 32'h5A5A5A5A};
            keep  = 8'hFF;
            last  = 1'b1;
            valid = 1'b1;
            @(negedge clk);
            checkOutput("ready_vs_level", 73'(ready), 73'(n < DEPTH));
            if (!ready) break;
            expQ.push_back({1'b1, 8'hFF, data});
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("accepted_at_full", 73'(n), 73'(DEPTH));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("full_ready_low", 73'(ready), 73'd0);
        end
        @(posedge clk);
        #1;
        valid     = 1'b0;
        ready_out = 1'b1;
        waitDrain();
        @(negedge clk);
        checkOutput("ready_reasserted", 73'(ready), 73'd1);
        @(posedge clk);
        #1;

        // Oversized frame exercises the full-FIFO cut-through fallback.
        applyStimulus(DEPTH + 3, 32'h0DD00007, 1'b1);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit (queued %0d)", expQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
